// File: rtl/arbiter_rr_sync.sv
// Round-robin arbiter sharing one four-phase req/ack channel among input_size requesters.
// Optional ack_out timeout abort is enabled by defining ARB_TIMEOUT_EN.
module arbiter_rr_sync #(
  parameter int unsigned input_size     = 8,
  parameter int unsigned timeout_cycles = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [input_size-1:0] req_in,
  output logic [input_size-1:0] ack_in,
  output logic                  req_out,
  input  logic                  ack_out,
  output logic [input_size-1:0] sel,
  output logic                  err
);

  localparam int unsigned N  = input_size;
  localparam int unsigned PW = $clog2(input_size);

  if (input_size < 2 || timeout_cycles < 1) begin : g_bad_params
    $error("arbiter_rr_sync: input_size must be >= 2 and timeout_cycles >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, ACK, DROP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   w_q, w_d;
  logic [N-1:0]    ack_in_q, ack_in_d;
  logic [N-1:0]    sel_q, sel_d;
  logic            req_out_q, req_out_d;
  logic            err_q, err_d;

  logic [PW-1:0]   pick_c;
  logic            pick_vld_c;
  logic [PW-1:0]   w_next_c;
  logic [N-1:0]    w_oh_c;
  int unsigned     idx_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(timeout_cycles + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  // First requester found scanning upward from ptr with wrap-around
  always_comb begin
    pick_c     = '0;
    pick_vld_c = 1'b0;
    idx_c      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_c = 32'(ptr_q) + k;
      if (idx_c >= N) idx_c = idx_c - N;
      if (!pick_vld_c && req_in[PW'(idx_c)]) begin
        pick_c     = PW'(idx_c);
        pick_vld_c = 1'b1;
      end
    end
  end

  assign w_oh_c   = N'(1) << w_q;
  assign w_next_c = (32'(w_q) == N - 1) ? '0 : PW'(32'(w_q) + 1);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    w_d       = w_q;
    ack_in_d  = ack_in_q;
    sel_d     = sel_q;
    req_out_d = req_out_q;
    err_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld_c) begin
          w_d       = pick_c;
          sel_d     = N'(1) << pick_c;
          req_out_d = 1'b1;
          state_d   = REQ;
`ifdef ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      REQ: begin
        if (ack_out) begin
          ack_in_d = w_oh_c;
          state_d  = ACK;
        end
`ifdef ARB_TIMEOUT_EN
        else if (32'(cnt_q) == timeout_cycles - 1) begin
          req_out_d = 1'b0;
          sel_d     = '0;
          err_d     = 1'b1;
          ptr_d     = w_next_c;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      ACK: begin
        if (!req_in[w_q]) begin
          req_out_d = 1'b0;
          state_d   = DROP;
        end
      end
      DROP: begin
        if (!ack_out) begin
          ack_in_d = '0;
          sel_d    = '0;
          ptr_d    = w_next_c;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      w_q       <= '0;
      ack_in_q  <= '0;
      sel_q     <= '0;
      req_out_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      w_q       <= w_d;
      ack_in_q  <= ack_in_d;
      sel_q     <= sel_d;
      req_out_q <= req_out_d;
      err_q     <= err_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign ack_in  = ack_in_q;
  assign sel     = sel_q;
  assign req_out = req_out_q;
  assign err     = err_q;

endmodule

// File: tb/tb_arbiter_rr_sync.sv
// Self-checking bench for arbiter_rr_sync: directed steps plus random requests against a round-robin model.
module tb_arbiter_rr_sync;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_in;
  logic [N-1:0] ack_in;
  logic         req_out;
  logic         ack_out;
  logic [N-1:0] sel;
  logic         err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ptr_m    = 0;
  logic err_exp  = 1'b0;

  always #5 clk = ~clk;

  arbiter_rr_sync #(.input_size(N), .timeout_cycles(4)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in),
    .req_out(req_out), .ack_out(ack_out), .sel(sel), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first set bit scanning ptr, ptr+1, ... modulo N
  function automatic int pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Advance one clock, sample 1 time unit after the edge, check invariants
  task automatic step();
    @(posedge clk);
    #1;
    chk("ack_sel_agree", 32'((ack_in == '0) || (ack_in == sel)), 32'd1);
    chk("err", 32'(err), 32'(err_exp));
  endtask

  task automatic do_reset();
    rst = 1'b0; req_in = 8'hFF; ack_out = 1'b0;
    step();
    step();
    chk("rst_ack_in", 32'(ack_in), 32'd0);
    chk("rst_req_out", 32'(req_out), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    rst = 1'b1;
    ptr_m = 0;
  endtask

  // Full four-phase transaction; exp_w < 0 means "use the model's pick"
  task automatic txn(input logic [N-1:0] r, input int exp_w, input string tag);
    int e;
    int d;
    logic [N-1:0] oh;
    e  = (exp_w >= 0) ? exp_w : pick(ptr_m, r);
    oh = 8'(1 << e);
    req_in = r; ack_out = 1'b0;
    step();
    chk({tag, "_sel"}, 32'(sel), 32'(oh));
    chk({tag, "_req_out"}, 32'(req_out), 32'd1);
    chk({tag, "_ack_in_req"}, 32'(ack_in), 32'd0);
    d = $urandom_range(0, 2);
    repeat (d) begin
      req_in = 8'($urandom) | oh;
      step();
      chk({tag, "_sel_hold"}, 32'(sel), 32'(oh));
      chk({tag, "_ack_in_hold0"}, 32'(ack_in), 32'd0);
    end
    ack_out = 1'b1;
    step();
    chk({tag, "_ack_in"}, 32'(ack_in), 32'(oh));
    chk({tag, "_req_out_ack"}, 32'(req_out), 32'd1);
    d = $urandom_range(0, 2);
    repeat (d) begin
      ack_out = 1'($urandom);
      req_in  = 8'($urandom) | oh;
      step();
      chk({tag, "_ack_in_ackhold"}, 32'(ack_in), 32'(oh));
      chk({tag, "_req_out_ackhold"}, 32'(req_out), 32'd1);
    end
    req_in = req_in & ~oh; ack_out = 1'b1;
    step();
    chk({tag, "_req_out_drop"}, 32'(req_out), 32'd0);
    chk({tag, "_ack_in_drop"}, 32'(ack_in), 32'(oh));
    ack_out = 1'b0;
    step();
    chk({tag, "_ack_in_idle"}, 32'(ack_in), 32'd0);
    chk({tag, "_sel_idle"}, 32'(sel), 32'd0);
    chk({tag, "_req_out_idle"}, 32'(req_out), 32'd0);
    ptr_m = (e + 1) % N;
  endtask

  initial begin
    int ord [4] = '{0, 2, 5, 7};
    rst = 1'b0; req_in = '0; ack_out = 1'b0;

    // Reset with all requests high, then first grant goes to index 0
    do_reset();
    txn(8'hFF, 0, "first_grant");

    // Single request from ptr 0; ptr then 5, proven by the next grant
    do_reset();
    txn(8'h10, 4, "single");
    txn(8'hFF, 5, "after_single");

    // Fairness on 8'hA5
    do_reset();
    for (int i = 0; i < 8; i++) txn(8'hA5, ord[i % 4], "fair");

    // Wrap-around: grant 6 -> ptr 7, then 7, then 0
    txn(8'h40, 6, "wrap_pre");
    txn(8'h81, 7, "wrap_7");
    txn(8'h81, 0, "wrap_0");

    // ack_out while idle is ignored
    req_in = '0; ack_out = 1'b1;
    step();
    step();
    chk("idle_ackout_req_out", 32'(req_out), 32'd0);
    chk("idle_ackout_ack_in", 32'(ack_in), 32'd0);
    chk("idle_ackout_sel", 32'(sel), 32'd0);
    ack_out = 1'b0;

    // Randomized requests against the model
    for (int i = 0; i < 30; i++) txn(8'($urandom_range(1, 255)), -1, "rand");

    // Reset while in ACK, then a fresh grant to index 2
    do_reset();
    req_in = 8'h04; ack_out = 1'b0;
    step();
    chk("midrst_sel", 32'(sel), 32'h04);
    ack_out = 1'b1;
    step();
    chk("midrst_ack_in", 32'(ack_in), 32'h04);
    rst = 1'b0;
    step();
    chk("midrst_ack_in_clr", 32'(ack_in), 32'd0);
    chk("midrst_sel_clr", 32'(sel), 32'd0);
    chk("midrst_req_out_clr", 32'(req_out), 32'd0);
    rst = 1'b1; ack_out = 1'b0;
    ptr_m = 0;
    txn(8'h04, 2, "midrst_regrant");

`ifdef ARB_TIMEOUT_EN
    // Timeout after 4 REQ cycles, err pulse, then index 0 wins from ptr 2
    do_reset();
    req_in = 8'h02; ack_out = 1'b0;
    step();
    chk("to_sel", 32'(sel), 32'h02);
    repeat (3) begin
      step();
      chk("to_req_out_hold", 32'(req_out), 32'd1);
      chk("to_ack_in_hold", 32'(ack_in), 32'd0);
    end
    err_exp = 1'b1;
    step();
    chk("to_req_out_drop", 32'(req_out), 32'd0);
    chk("to_sel_clr", 32'(sel), 32'd0);
    chk("to_ack_in", 32'(ack_in), 32'd0);
    err_exp = 1'b0;
    ptr_m = 2;
    txn(8'h03, 0, "to_regrant");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
